// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - ILI9341 opcodes, receiver state encoding and default window ends
package lcd_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    localparam logic [8:0] COL_END_DEFAULT  = 9'd239;
    localparam logic [8:0] PAGE_END_DEFAULT = 9'd319;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARAM = 2'd1,
        ST_PIX_A = 2'd2,
        ST_PIX_B = 2'd3
    } lcd_state_t;

endpackage

// File: rtl/lcd_wr_edge.sv
// rtl/lcd_wr_edge.sv - WR rising-edge detector; LCD_SINK_INPUT_SYNC_EN adds a 2-flop input synchronizer
module lcd_wr_edge (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_evt,
    output logic       o_rs,
    output logic [7:0] o_data
);

    logic       wr_src;
    logic       wr_q;

`ifdef LCD_SINK_INPUT_SYNC_EN
    logic [1:0] wr_s;
    logic [1:0] rs_s;
    logic [7:0] data_s0;
    logic [7:0] data_s1;

    // WR idles high, so the synchronizer resets high to avoid a phantom edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_s    <= 2'b11;
            rs_s    <= 2'b00;
            data_s0 <= 8'h00;
            data_s1 <= 8'h00;
        end else begin
            wr_s    <= {wr_s[0], i_wr};
            rs_s    <= {rs_s[0], i_rs};
            data_s0 <= i_data;
            data_s1 <= data_s0;
        end
    end

    assign wr_src = wr_s[1];
    assign o_rs   = rs_s[1];
    assign o_data = data_s1;
`else
    assign wr_src = i_wr;
    assign o_rs   = i_rs;
    assign o_data = i_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_q <= 1'b1;
        end else begin
            wr_q <= wr_src;
        end
    end

    assign o_evt = ~wr_q & wr_src;

endmodule

// File: rtl/lcd_bus_sink.sv
// rtl/lcd_bus_sink.sv - ILI9341 8080 write-bus receiver; LCD_SINK_INPUT_SYNC_EN selects synchronized inputs
module lcd_bus_sink
    import lcd_pkg::*;
#(
    parameter logic [8:0] COL_RST_END    = COL_END_DEFAULT,
    parameter logic [8:0] PAGE_RST_END   = PAGE_END_DEFAULT,
    parameter bit         LOW_BYTE_FIRST = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_lcd_data,
    input  logic        i_lcd_rs,
    input  logic        i_lcd_wr,
    output logic        o_pix_valid,
    output logic [8:0]  o_pix_x,
    output logic [8:0]  o_pix_y,
    output logic [15:0] o_pix_data,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd,
    output logic        o_display_on,
    output logic        o_sleep_out,
    output logic        o_frame_done,
    output logic        o_stray
);

    logic       ev;
    logic       ev_rs;
    logic [7:0] ev_data;

    lcd_wr_edge u_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (i_lcd_wr),
        .i_rs    (i_lcd_rs),
        .i_data  (i_lcd_data),
        .o_evt   (ev),
        .o_rs    (ev_rs),
        .o_data  (ev_data)
    );

    lcd_state_t state_q, state_n;
    logic [1:0] idx_q, idx_n;
    logic       tgt_q, tgt_n;           // 0: column window, 1: page window
    logic       start_hi_q, start_hi_n;
    logic [7:0] start_lo_q, start_lo_n;
    logic       end_hi_q, end_hi_n;
    logic [7:0] byte_a_q, byte_a_n;
    logic [8:0] sc_q, sc_n, ec_q, ec_n, sp_q, sp_n, ep_q, ep_n;
    logic [8:0] col_q, col_n, page_q, page_n;
    logic       skip_q, skip_n;         // unknown command seen: swallow its parameters
    logic       pix_v_n, cmd_v_n, fd_n, stray_n, disp_n, sleep_n;
    logic [8:0] x_n, y_n;
    logic [15:0] data_n;
    logic [7:0] cmd_n;

    always_comb begin
        state_n = state_q;   idx_n = idx_q;   tgt_n = tgt_q;
        start_hi_n = start_hi_q;  start_lo_n = start_lo_q;  end_hi_n = end_hi_q;
        byte_a_n = byte_a_q;
        sc_n = sc_q;  ec_n = ec_q;  sp_n = sp_q;  ep_n = ep_q;
        col_n = col_q;  page_n = page_q;  skip_n = skip_q;
        disp_n = o_display_on;  sleep_n = o_sleep_out;  cmd_n = o_cmd;
        x_n = o_pix_x;  y_n = o_pix_y;  data_n = o_pix_data;
        pix_v_n = 1'b0;  cmd_v_n = 1'b0;  fd_n = 1'b0;  stray_n = 1'b0;

        if (ev && !ev_rs) begin
            cmd_v_n = 1'b1;
            cmd_n   = ev_data;
            skip_n  = 1'b0;
            state_n = ST_IDLE;
            case (ev_data)
                CMD_CASET, CMD_PASET: begin
                    state_n = ST_PARAM;
                    idx_n   = 2'd0;
                    tgt_n   = (ev_data == CMD_PASET);
                end
                CMD_RAMWR: begin
                    col_n   = sc_q;
                    page_n  = sp_q;
                    state_n = ST_PIX_A;
                end
                CMD_RAMWRC: state_n = ST_PIX_A;
                CMD_SWRESET: begin
                    sc_n = 9'd0;  ec_n = COL_RST_END;
                    sp_n = 9'd0;  ep_n = PAGE_RST_END;
                    col_n = 9'd0; page_n = 9'd0;
                    disp_n = 1'b0; sleep_n = 1'b0;
                end
                CMD_SLPIN:   sleep_n = 1'b0;
                CMD_SLPOUT:  sleep_n = 1'b1;
                CMD_DISPOFF: disp_n  = 1'b0;
                CMD_DISPON:  disp_n  = 1'b1;
                default:     skip_n  = 1'b1;
            endcase
        end else if (ev) begin
            case (state_q)
                ST_IDLE: stray_n = ~skip_q;
                ST_PARAM: begin
                    idx_n = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: start_hi_n = ev_data[0];
                        2'd1: start_lo_n = ev_data;
                        2'd2: end_hi_n   = ev_data[0];
                        default: begin
                            state_n = ST_IDLE;
                            if (tgt_q) begin
                                sp_n = {start_hi_q, start_lo_q};
                                ep_n = {end_hi_q, ev_data};
                            end else begin
                                sc_n = {start_hi_q, start_lo_q};
                                ec_n = {end_hi_q, ev_data};
                            end
                        end
                    endcase
                end
                ST_PIX_A: begin
                    byte_a_n = ev_data;
                    state_n  = ST_PIX_B;
                end
                default: begin
                    pix_v_n = 1'b1;
                    x_n     = col_q;
                    y_n     = page_q;
                    data_n  = LOW_BYTE_FIRST ? {ev_data, byte_a_q} : {byte_a_q, ev_data};
                    state_n = ST_PIX_A;
                    // >= rather than == so a start>end window collapses to one column/row
                    if (col_q >= ec_q) begin
                        col_n = sc_q;
                        if (page_q >= ep_q) begin
                            page_n = sp_q;
                            fd_n   = 1'b1;
                        end else begin
                            page_n = page_q + 9'd1;
                        end
                    end else begin
                        col_n = col_q + 9'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;  idx_q <= 2'd0;  tgt_q <= 1'b0;
            start_hi_q <= 1'b0;  start_lo_q <= 8'h00;  end_hi_q <= 1'b0;
            byte_a_q <= 8'h00;
            sc_q <= 9'd0;  ec_q <= COL_RST_END;  sp_q <= 9'd0;  ep_q <= PAGE_RST_END;
            col_q <= 9'd0;  page_q <= 9'd0;  skip_q <= 1'b0;
            o_pix_valid <= 1'b0;  o_pix_x <= 9'd0;  o_pix_y <= 9'd0;  o_pix_data <= 16'h0000;
            o_cmd_valid <= 1'b0;  o_cmd <= 8'h00;
            o_display_on <= 1'b0;  o_sleep_out <= 1'b0;
            o_frame_done <= 1'b0;  o_stray <= 1'b0;
        end else begin
            state_q <= state_n;  idx_q <= idx_n;  tgt_q <= tgt_n;
            start_hi_q <= start_hi_n;  start_lo_q <= start_lo_n;  end_hi_q <= end_hi_n;
            byte_a_q <= byte_a_n;
            sc_q <= sc_n;  ec_q <= ec_n;  sp_q <= sp_n;  ep_q <= ep_n;
            col_q <= col_n;  page_q <= page_n;  skip_q <= skip_n;
            o_pix_valid <= pix_v_n;  o_pix_x <= x_n;  o_pix_y <= y_n;  o_pix_data <= data_n;
            o_cmd_valid <= cmd_v_n;  o_cmd <= cmd_n;
            o_display_on <= disp_n;  o_sleep_out <= sleep_n;
            o_frame_done <= fd_n;  o_stray <= stray_n;
        end
    end

endmodule

// File: tb/tb_lcd_bus_sink.sv
// tb/tb_lcd_bus_sink.sv - directed self-checking bench for lcd_bus_sink
module tb_lcd_bus_sink;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  lcd_data = 8'h00;
    logic        lcd_rs = 1'b0;
    logic        lcd_wr = 1'b1;
    logic        pix_valid, cmd_valid, display_on, sleep_out, frame_done, stray;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_data;
    logic [7:0]  cmd;

    int checks = 0;
    int failures = 0;

`ifdef LCD_SINK_INPUT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
        logic        fd;
    } pix_t;

    pix_t pq[$];
    int   stray_cnt = 0;
    int   fd_cnt = 0;

    lcd_bus_sink dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_lcd_data   (lcd_data),
        .i_lcd_rs     (lcd_rs),
        .i_lcd_wr     (lcd_wr),
        .o_pix_valid  (pix_valid),
        .o_pix_x      (pix_x),
        .o_pix_y      (pix_y),
        .o_pix_data   (pix_data),
        .o_cmd_valid  (cmd_valid),
        .o_cmd        (cmd),
        .o_display_on (display_on),
        .o_sleep_out  (sleep_out),
        .o_frame_done (frame_done),
        .o_stray      (stray)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pix_valid) begin
            pix_t p;
            p.x = pix_x; p.y = pix_y; p.d = pix_data; p.fd = frame_done;
            pq.push_back(p);
        end
        if (stray) stray_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; lcd_wr = 1'b1; lcd_rs = 1'b0; lcd_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pq.delete();
        stray_cnt = 0;
        fd_cnt = 0;
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] d);
        @(negedge clk);
        lcd_wr = 1'b0; lcd_rs = rs; lcd_data = d;
        repeat (2) @(negedge clk);
        lcd_wr = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_pix(input logic [15:0] p);
        send_byte(1'b1, p[7:0]);
        send_byte(1'b1, p[15:8]);
    endtask

    task automatic send_window(input logic [7:0] c, input logic [8:0] s, input logic [8:0] e);
        send_byte(1'b0, c);
        send_byte(1'b1, {7'd0, s[8]});
        send_byte(1'b1, s[7:0]);
        send_byte(1'b1, {7'd0, e[8]});
        send_byte(1'b1, e[7:0]);
    endtask

    task automatic settle();
        repeat (4 + SYNC_LAT) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pix_valid, cmd_valid, frame_done, stray} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses got=%b exp=0000", {pix_valid, cmd_valid, frame_done, stray});
        end
        checks++;
        if ({pix_x, pix_y, pix_data, cmd, display_on, sleep_out} !== 44'd0) begin
            failures++;
            $display("FAIL reset_values x=%0d y=%0d d=%h cmd=%h don=%b slp=%b exp all zero",
                     pix_x, pix_y, pix_data, cmd, display_on, sleep_out);
        end
    endtask

    task automatic test_first_pixel();
        logic seen;
        do_reset();
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h1F);
        @(negedge clk);
        lcd_wr = 1'b0; lcd_rs = 1'b1; lcd_data = 8'hF8;
        repeat (2) @(negedge clk);
        lcd_wr = 1'b1;
        repeat (SYNC_LAT) @(posedge clk);
        @(posedge clk);
        #1 seen = pix_valid;
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL first_pix_latency pix_valid=%b exp=1", seen);
        end
        settle();
        checks++;
        if (pq.size() != 1) begin
            failures++;
            $display("FAIL first_pix_count got=%0d exp=1", pq.size());
        end else begin
            checks++;
            if (pq[0].d !== 16'hF81F || pq[0].x !== 9'd0 || pq[0].y !== 9'd0) begin
                failures++;
                $display("FAIL first_pix_value got d=%h x=%0d y=%0d exp d=f81f x=0 y=0",
                         pq[0].d, pq[0].x, pq[0].y);
            end
        end
    endtask

    task automatic test_window();
        logic [8:0] ex[5] = '{9'd10, 9'd11, 9'd10, 9'd11, 9'd10};
        logic [8:0] ey[5] = '{9'd5, 9'd5, 9'd6, 9'd6, 9'd5};
        do_reset();
        send_window(8'h2A, 9'd10, 9'd11);
        send_window(8'h2B, 9'd5, 9'd6);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) send_pix(16'hA000 | 16'(i));
        settle();
        checks++;
        if (pq.size() != 5) begin
            failures++;
            $display("FAIL window_count got=%0d exp=5", pq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (pq[i].x !== ex[i] || pq[i].y !== ey[i] || pq[i].d !== (16'hA000 | 16'(i))
                    || pq[i].fd !== (i == 3)) begin
                    failures++;
                    $display("FAIL window_pix%0d got x=%0d y=%0d d=%h fd=%b exp x=%0d y=%0d d=%h fd=%b",
                             i, pq[i].x, pq[i].y, pq[i].d, pq[i].fd, ex[i], ey[i],
                             16'hA000 | 16'(i), (i == 3));
                end
            end
        end
        checks++;
        if (fd_cnt != 1) begin
            failures++;
            $display("FAIL window_frame_done_count got=%0d exp=1", fd_cnt);
        end
    endtask

    task automatic test_interrupted_param();
        do_reset();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h14);
        send_byte(1'b0, 8'h29);
        settle();
        checks++;
        if (display_on !== 1'b1 || cmd !== 8'h29) begin
            failures++;
            $display("FAIL interrupt_status don=%b cmd=%h exp don=1 cmd=29", display_on, cmd);
        end
        send_byte(1'b0, 8'h2C);
        send_pix(16'h1234);
        settle();
        checks++;
        if (pq.size() != 1 || pq[0].x !== 9'd0 || pq[0].y !== 9'd0 || pq[0].d !== 16'h1234) begin
            failures++;
            $display("FAIL interrupt_window n=%0d x=%0d y=%0d d=%h exp n=1 x=0 y=0 d=1234",
                     pq.size(), pq.size() ? pq[0].x : 9'd0, pq.size() ? pq[0].y : 9'd0,
                     pq.size() ? pq[0].d : 16'd0);
        end
    endtask

    task automatic test_ramwrc_discard();
        do_reset();
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h34);
        send_byte(1'b0, 8'h3C);
        send_byte(1'b1, 8'h78);
        send_byte(1'b1, 8'h56);
        settle();
        checks++;
        if (pq.size() != 1 || pq[0].d !== 16'h5678 || pq[0].x !== 9'd0 || pq[0].y !== 9'd0) begin
            failures++;
            $display("FAIL ramwrc_discard n=%0d d=%h x=%0d y=%0d exp n=1 d=5678 x=0 y=0",
                     pq.size(), pq.size() ? pq[0].d : 16'd0, pq.size() ? pq[0].x : 9'd0,
                     pq.size() ? pq[0].y : 9'd0);
        end
        send_byte(1'b0, 8'h3C);
        send_pix(16'h9ABC);
        settle();
        checks++;
        if (pq.size() != 2 || pq[1].x !== 9'd1 || pq[1].y !== 9'd0) begin
            failures++;
            $display("FAIL ramwrc_continue n=%0d x=%0d exp n=2 x=1 y=0",
                     pq.size(), pq.size() > 1 ? pq[1].x : 9'd0);
        end
    endtask

    task automatic test_stray();
        do_reset();
        send_byte(1'b1, 8'hAA);
        settle();
        checks++;
        if (stray_cnt != 1 || pq.size() != 0) begin
            failures++;
            $display("FAIL stray_after_reset stray=%0d pix=%0d exp stray=1 pix=0", stray_cnt, pq.size());
        end
        send_byte(1'b0, 8'hB1);
        send_byte(1'b1, 8'h01);
        send_byte(1'b1, 8'h1B);
        settle();
        checks++;
        if (stray_cnt != 1) begin
            failures++;
            $display("FAIL stray_unknown_cmd stray=%0d exp=1", stray_cnt);
        end
        send_byte(1'b0, 8'h11);
        send_byte(1'b1, 8'h55);
        settle();
        checks++;
        if (stray_cnt != 2 || sleep_out !== 1'b1) begin
            failures++;
            $display("FAIL stray_after_slpout stray=%0d slp=%b exp stray=2 slp=1", stray_cnt, sleep_out);
        end
    endtask

    task automatic test_start_gt_end();
        do_reset();
        send_window(8'h2A, 9'd5, 9'd3);
        send_byte(1'b0, 8'h2C);
        send_pix(16'h0001);
        send_pix(16'h0002);
        settle();
        checks++;
        if (pq.size() != 2 || pq[0].x !== 9'd5 || pq[0].y !== 9'd0
            || pq[1].x !== 9'd5 || pq[1].y !== 9'd1) begin
            failures++;
            $display("FAIL start_gt_end n=%0d p0=(%0d,%0d) p1=(%0d,%0d) exp n=2 (5,0) (5,1)",
                     pq.size(), pq.size() ? pq[0].x : 9'd0, pq.size() ? pq[0].y : 9'd0,
                     pq.size() > 1 ? pq[1].x : 9'd0, pq.size() > 1 ? pq[1].y : 9'd0);
        end
        send_byte(1'b0, 8'h29);
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h2C);
        send_pix(16'h0003);
        settle();
        checks++;
        if (pq.size() != 3 || pq[2].x !== 9'd0 || pq[2].y !== 9'd0 || display_on !== 1'b0) begin
            failures++;
            $display("FAIL swreset n=%0d x=%0d y=%0d don=%b exp n=3 x=0 y=0 don=0", pq.size(),
                     pq.size() > 2 ? pq[2].x : 9'd0, pq.size() > 2 ? pq[2].y : 9'd0, display_on);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(1'b0, 8'h29);
        send_window(8'h2A, 9'd5, 9'd6);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h11);
        do_reset();
        checks++;
        if (display_on !== 1'b0 || cmd !== 8'h00) begin
            failures++;
            $display("FAIL midreset_status don=%b cmd=%h exp don=0 cmd=00", display_on, cmd);
        end
        send_byte(1'b1, 8'h22);
        settle();
        checks++;
        if (pq.size() != 0 || stray_cnt != 1) begin
            failures++;
            $display("FAIL midreset_partial pix=%0d stray=%0d exp pix=0 stray=1", pq.size(), stray_cnt);
        end
        send_byte(1'b0, 8'h2C);
        send_pix(16'hBEEF);
        settle();
        checks++;
        if (pq.size() != 1 || pq[0].x !== 9'd0 || pq[0].y !== 9'd0 || pq[0].d !== 16'hBEEF) begin
            failures++;
            $display("FAIL midreset_restart n=%0d x=%0d y=%0d exp n=1 x=0 y=0 d=beef",
                     pq.size(), pq.size() ? pq[0].x : 9'd0, pq.size() ? pq[0].y : 9'd0);
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_window();
        test_interrupted_param();
        test_ramwrc_discard();
        test_stray();
        test_start_gt_end();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
